pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter and sequences the next-PC calculation for the multi-cycle core. Fetches one instruction from instruction memory through a req/ack handshake, then presents it to the datapath. On datapath acceptance it applies the datapath's NPC operation (sequential, branch, jump, register) to advance the PC. Sits between instruction memory and the decode/execute datapath, and replaces the free-running PC register of the single-cycle design.

## Interface
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, no other reset
- if_req  out  1  fetch request to instruction memory
- if_addr  out  32  fetch address; always equals pc
- if_ack  in  1  fetch data valid; sampled only in FETCH
- if_rdata  in  32  fetched instruction word
- instr  out  32  latched instruction
- instr_valid  out  1  instr offered to datapath
- dp_ready  in  1  datapath accepts instr this cycle
- npc_op  in  2  00 seq, 01 branch, 10 jump, 11 register; sampled on accept
- npc_imm  in  26  branch uses [15:0], jump uses [25:0]
- npc_reg  in  32  target for op 11
- halt  in  1  stop after the accepted instruction
- pc  out  32  current PC
- retired  out  32  count of accepted instructions, wraps at 2^32
- halted  out  1  sticky, set in HALT
- err  out  1  sticky, set in ERR (misaligned target)

## Operation
- States: FETCH, ISSUE, HALT, ERR. Reset enters FETCH.
- FETCH: if_req=1. On if_ack: instr<=if_rdata, go to ISSUE. Without if_ack, stay in FETCH, with no timeout.
- ISSUE: instr_valid=1, instr held stable. An accept is instr_valid & dp_ready. On accept:
  - retired += 1.
  - Compute target; pc4 = pc + 4.
  - op 00: pc4.
  - op 01: pc4 + (sext(npc_imm[15:0]) << 2).
  - op 10: {pc4[31:28], npc_imm, 2'b00}.
  - op 11: npc_reg.
- Arithmetic is 32-bit, modulo 2^32. Wrap-around past 32'hFFFF_FFFC is legal.
- On accept, state selection in priority order:
  - Target[1:0] != 0: go to ERR. pc is unchanged, err=1, and the instruction still counts as retired.
  - Else halt=1: pc<=target, go to HALT.
  - Else: pc<=target, go to FETCH.
- HALT and ERR are terminal; only reset leaves them. In these states, if_req=0 and instr_valid=0.
- if_ack outside FETCH, and dp_ready outside ISSUE, are ignored.
- npc_op, npc_imm, npc_reg and halt are don't-care outside an accept cycle.

## Timing
- Reset values: pc=RESET_PC, if_req=1 (the FETCH output, asserted in the first cycle after reset), instr=0, instr_valid=0, retired=0, halted=0, err=0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Zero-wait memory: if_ack may be high in the first FETCH cycle. Minimum rate is 2 cycles per instruction (1 FETCH + 1 ISSUE).
- pc and if_addr update on the clock edge after the accept. The next FETCH presents the new address immediately.
- Reset mid-operation (any state, including an accept or ack cycle) wins: the ack/accept is discarded and all reset values apply on that edge.
- halt together with a misaligned target: ERR wins, halted stays 0.

## Structure
- Shared package `seq_pkg`:
  - NPC op encodings NPC_SEQ/NPC_BR/NPC_J/NPC_JR.
  - State encoding.
  - RESET_PC default.
- Sub-module `npc_calc`: purely combinational (pc, op, imm, reg) -> target and misalign flag. It is the only place where target arithmetic lives.
- Top level holds the FSM, pc/instr/retired registers and the sticky flags.

## Test plan
- Reset, then if_ack=1 every cycle, dp_ready=1, op 00 -> if_addr sequence 3000, 3004, 3008 at 2 cycles per step; retired=3 after the third accept.
- pc=3004, op 01, imm[15:0]=16'hFFFF -> pc=3004; imm=16'h0003 -> pc=3014.
- pc=3008, op 10, imm=26'h0000C10 -> pc=0000_3040 (pc4[31:28]=0).
- op 11, npc_reg=0000_3002 -> err=1, pc unchanged, if_req=0 thereafter. A following reset restores pc=3000 and err=0.
- if_ack held low 5 cycles, dp_ready low 3 cycles -> instr and if_addr are stable throughout, retired is unchanged, no extra fetch occurs.
- halt=1 on an accept with op 00 at pc=3010 -> pc=3014, halted=1, no further if_req. A reset asserted in the same cycle as an if_ack -> instr stays 0 and pc=RESET_PC.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC operation
// encodings, sequencer state encoding and the default reset PC.
package seq_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_ISSUE = 2'b01,
    S_HALT  = 2'b10,
    S_ERR   = 2'b11
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target calculation: sequential, PC-relative branch,
// region jump and register-indirect, plus a misalignment flag on the result.
module npc_calc
  import seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  op,
  input  logic [25:0] imm,
  input  logic [31:0] rs,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{imm[15]}}, imm[15:0], 2'b00};

  always_comb begin
    target = pc4;
    unique case (npc_op_e'(op))
      NPC_SEQ: target = pc4;
      NPC_BR:  target = pc4 + br_off;
      NPC_J:   target = {pc4[31:28], imm, 2'b00};
      NPC_JR:  target = rs;
      default: target = pc4;
    endcase
  end

  assign misalign = |target[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the multi-cycle core: fetches one instruction per
// req/ack handshake, issues it to the datapath and advances the PC on accept.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        dp_ready,
  input  logic [1:0]  npc_op,
  input  logic [25:0] npc_imm,
  input  logic [31:0] npc_reg,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic        err
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic [31:0] target;
  logic        misalign;
  logic        accept;
  logic        fetch_done;

  npc_calc u_npc_calc (
    .pc       (pc_q),
    .op       (npc_op),
    .imm      (npc_imm),
    .rs       (npc_reg),
    .target   (target),
    .misalign (misalign)
  );

  assign fetch_done = (state_q == S_FETCH) && if_ack;
  assign accept     = (state_q == S_ISSUE) && dp_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (if_ack) state_d = S_ISSUE;
      S_ISSUE: begin
        // misalignment outranks halt so a bad target never reports halted
        if (dp_ready) begin
          if (misalign)  state_d = S_ERR;
          else if (halt) state_d = S_HALT;
          else           state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (fetch_done) instr_q <= if_rdata;
      if (accept) begin
        retired_q <= retired_q + 32'd1;
        if (!misalign) pc_q <= target;
      end
    end
  end

  assign if_req      = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);
  assign err         = (state_q == S_ERR);
  assign if_addr     = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, compared each cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        dp_ready;
  logic [1:0]  npc_op;
  logic [25:0] npc_imm;
  logic [31:0] npc_reg;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;
  logic        err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // model: mode 0 = waiting for fetch, 1 = offering, 2 = halted, 3 = error
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ret;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata), .instr(instr),
    .instr_valid(instr_valid), .dp_ready(dp_ready), .npc_op(npc_op),
    .npc_imm(npc_imm), .npc_reg(npc_reg), .halt(halt), .pc(pc),
    .retired(retired), .halted(halted), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic [1:0] op,
                                             input logic [25:0] imm, input logic [31:0] rg);
    logic [31:0] nxt;
    logic signed [31:0] off;
    nxt = cur + 32'd4;
    off = 32'($signed(imm[15:0])) * 4;
    case (op)
      2'd0: return nxt;
      2'd1: return nxt + off;
      2'd2: return (nxt & 32'hF000_0000) | (32'(imm) * 4);
      default: return rg;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] t;
    if (reset) begin
      m_mode = 0; m_pc = 32'h0000_3000; m_instr = 0; m_ret = 0;
    end else if (m_mode == 0) begin
      if (if_ack) begin m_instr = if_rdata; m_mode = 1; end
    end else if (m_mode == 1 && dp_ready) begin
      m_ret = m_ret + 1;
      t = ref_target(m_pc, npc_op, npc_imm, npc_reg);
      if (t % 4 != 0) m_mode = 3;
      else begin
        m_pc = t;
        m_mode = halt ? 2 : 0;
      end
    end
  endtask

  task automatic compare_all();
    check("if_req",      32'(if_req),      32'(m_mode == 0));
    check("instr_valid", 32'(instr_valid), 32'(m_mode == 1));
    check("halted",      32'(halted),      32'(m_mode == 2));
    check("err",         32'(err),         32'(m_mode == 3));
    check("pc",          pc,               m_pc);
    check("if_addr",     if_addr,          m_pc);
    check("instr",       instr,            m_instr);
    check("retired",     retired,          m_ret);
  endtask

  // Drives one cycle of inputs (called at a negedge), lets the edge happen,
  // then compares at the following negedge.
  task automatic cyc(input bit r, input bit a, input logic [31:0] rd, input bit dr,
                     input logic [1:0] op, input logic [25:0] imm,
                     input logic [31:0] rg, input bit h);
    reset = r; if_ack = a; if_rdata = rd; dp_ready = dr;
    npc_op = op; npc_imm = imm; npc_reg = rg; halt = h;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic seq_step();
    cyc(0, 1, $urandom, 0, 2'd0, 26'd0, 32'd0, 0);
    cyc(0, 0, $urandom, 1, 2'd0, 26'd0, 32'd0, 0);
  endtask

  initial begin
    m_mode = 0; m_pc = 0; m_instr = 0; m_ret = 0;
    @(negedge clk);

    // sequential fetch stream at zero-wait memory
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    check("reset_addr", if_addr, 32'h0000_3000);
    check("reset_req", 32'(if_req), 32'd1);
    cyc(0, 1, 32'h1111_0000, 1, 2'd0, 0, 0, 0);
    cyc(0, 1, 32'h1111_0001, 1, 2'd0, 0, 0, 0);
    check("seq_addr1", if_addr, 32'h0000_3004);
    cyc(0, 1, 32'h1111_0002, 1, 2'd0, 0, 0, 0);
    cyc(0, 1, 32'h1111_0003, 1, 2'd0, 0, 0, 0);
    check("seq_addr2", if_addr, 32'h0000_3008);
    cyc(0, 1, 32'h1111_0004, 1, 2'd0, 0, 0, 0);
    cyc(0, 1, 32'h1111_0005, 1, 2'd0, 0, 0, 0);
    check("seq_retired3", retired, 32'd3);

    // branch backward to self, then forward
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    seq_step();
    cyc(0, 1, 32'h2222_0000, 0, 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2'd1, 26'h000FFFF, 0, 0);
    check("br_neg", pc, 32'h0000_3004);
    cyc(0, 1, 32'h2222_0001, 0, 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2'd1, 26'h3FF0003, 0, 0);
    check("br_pos", pc, 32'h0000_3014);

    // jump within the 256 MB region, then misaligned register target
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    seq_step();
    seq_step();
    cyc(0, 1, 32'h3333_0000, 0, 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2'd2, 26'h0000C10, 0, 0);
    check("jump", pc, 32'h0000_3040);
    cyc(0, 1, 32'h3333_0001, 0, 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2'd3, 0, 32'h0000_3002, 1);
    check("jr_err", 32'(err), 32'd1);
    check("jr_no_halt", 32'(halted), 32'd0);
    check("jr_pc_hold", pc, 32'h0000_3040);
    cyc(0, 1, 0, 1, 2'd0, 0, 0, 0);
    check("err_no_req", 32'(if_req), 32'd0);
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    check("err_cleared", 32'(err), 32'd0);
    check("err_reset_pc", pc, 32'h0000_3000);

    // stalls on both handshakes
    for (int i = 0; i < 5; i++) cyc(0, 0, 32'hBAD0_0000, 1, 2'd0, 0, 0, 0);
    check("stall_addr", if_addr, 32'h0000_3000);
    cyc(0, 1, 32'hA5A5_5A5A, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hBAD0_0001, 0, 2'd0, 0, 0, 0);
    check("stall_instr", instr, 32'hA5A5_5A5A);
    check("stall_retired", retired, 32'd0);
    cyc(0, 0, 0, 1, 2'd0, 0, 0, 0);

    // halt after an accept at 3010
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) seq_step();
    check("pre_halt_pc", pc, 32'h0000_3010);
    cyc(0, 1, 32'h4444_0000, 0, 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2'd0, 0, 0, 1);
    check("halt_pc", pc, 32'h0000_3014);
    check("halt_flag", 32'(halted), 32'd1);
    cyc(0, 1, 0, 1, 2'd0, 0, 0, 0);
    check("halt_no_req", 32'(if_req), 32'd0);

    // reset coincident with an ack discards the fetch
    cyc(1, 0, 0, 0, 2'd0, 0, 0, 0);
    cyc(1, 1, 32'hDEAD_BEEF, 1, 2'd0, 0, 0, 0);
    check("rst_ack_instr", instr, 32'd0);
    check("rst_ack_pc", pc, 32'h0000_3000);

    // random traffic including wrap-around targets
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rg;
      logic [25:0] imm;
      rg  = $urandom;
      if ($urandom_range(3) != 0) rg[1:0] = 2'b00;
      imm = 26'($urandom);
      cyc(($urandom_range(40) == 0), $urandom_range(1) == 1, $urandom,
          $urandom_range(1) == 1, 2'($urandom_range(3)), imm, rg,
          ($urandom_range(15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
